// File: rtl/mem_responder_pkg.sv
// Shared types for mem_responder: per-channel FSM state encoding and latency counter width.
package mem_responder_pkg;

    localparam int unsigned CNT_BITS = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_BUSY_RD = 3'd1,
        ST_BUSY_WR = 3'd2,
        ST_RESPOND = 3'd3,
        ST_DRAIN   = 3'd4
    } chan_state_t;

endpackage

// File: rtl/mem_responder_channel.sv
// One request channel: accepts a read or write, counts out LATENCY cycles, then fires a
// one-cycle commit toward the shared array and a one-cycle ready pulse.
module mem_responder_channel
    import mem_responder_pkg::*;
#(
    parameter int unsigned ADDR_BITS = 8,
    parameter int unsigned DATA_BITS = 16,
    parameter int unsigned LATENCY   = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 read_valid,
    input  logic [ADDR_BITS-1:0] read_address,
    input  logic                 write_valid,
    input  logic [ADDR_BITS-1:0] write_address,
    input  logic [DATA_BITS-1:0] write_data,
    output logic                 read_ready,
    output logic                 write_ready,
    output logic                 rd_fire,
    output logic [ADDR_BITS-1:0] rd_addr,
    output logic                 wr_fire,
    output logic [ADDR_BITS-1:0] wr_addr,
    output logic [DATA_BITS-1:0] wr_data
);

    localparam logic [CNT_BITS-1:0] CNT_LOAD = CNT_BITS'(LATENCY - 1);

    chan_state_t          state, next_state;
    logic [CNT_BITS-1:0]  cnt, cnt_next;
    logic [ADDR_BITS-1:0] addr_q, addr_next;
    logic [DATA_BITS-1:0] data_q, data_next;
    logic                 op_rd_q, op_rd_next;
    logic                 held_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            op_rd_q <= 1'b0;
        end else begin
            state   <= next_state;
            cnt     <= cnt_next;
            addr_q  <= addr_next;
            data_q  <= data_next;
            op_rd_q <= op_rd_next;
        end
    end

    // With LATENCY=1 the commit happens on the accept edge, so it uses the live request fields.
    always_comb begin
        next_state = state;
        cnt_next   = cnt;
        addr_next  = addr_q;
        data_next  = data_q;
        op_rd_next = op_rd_q;
        rd_fire    = 1'b0;
        wr_fire    = 1'b0;
        rd_addr    = addr_q;
        wr_addr    = addr_q;
        wr_data    = data_q;
        held_valid = op_rd_q ? read_valid : write_valid;

        case (state)
            ST_IDLE: begin
                if (read_valid) begin
                    addr_next  = read_address;
                    op_rd_next = 1'b1;
                    if (LATENCY == 1) begin
                        next_state = ST_RESPOND;
                        cnt_next   = '0;
                        rd_fire    = 1'b1;
                        rd_addr    = read_address;
                    end else begin
                        next_state = ST_BUSY_RD;
                        cnt_next   = CNT_LOAD;
                    end
                end else if (write_valid) begin
                    addr_next  = write_address;
                    data_next  = write_data;
                    op_rd_next = 1'b0;
                    if (LATENCY == 1) begin
                        next_state = ST_RESPOND;
                        cnt_next   = '0;
                        wr_fire    = 1'b1;
                        wr_addr    = write_address;
                        wr_data    = write_data;
                    end else begin
                        next_state = ST_BUSY_WR;
                        cnt_next   = CNT_LOAD;
                    end
                end
            end
            ST_BUSY_RD: begin
                if (cnt == '0) begin
                    next_state = ST_RESPOND;
                    rd_fire    = 1'b1;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            ST_BUSY_WR: begin
                if (cnt == '0) begin
                    next_state = ST_RESPOND;
                    wr_fire    = 1'b1;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            ST_RESPOND: begin
                next_state = held_valid ? ST_DRAIN : ST_IDLE;
            end
            ST_DRAIN: begin
                if (!held_valid) next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    assign read_ready  = (state == ST_RESPOND) &&  op_rd_q;
    assign write_ready = (state == ST_RESPOND) && !op_rd_q;

endmodule

// File: rtl/mem_responder.sv
// Multi-channel memory responder: shared array, per-channel latency FSMs, write-priority merge
// (higher channel beats lower, backdoor init beats all channels).
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int unsigned ADDR_BITS    = 8,
    parameter int unsigned DATA_BITS    = 16,
    parameter int unsigned NUM_CHANNELS = 1,
    parameter int unsigned LATENCY      = 2,
    parameter int unsigned WRITE_ENABLE = 1
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_CHANNELS-1:0]           mem_read_valid,
    input  logic [NUM_CHANNELS*ADDR_BITS-1:0] mem_read_address,
    output logic [NUM_CHANNELS-1:0]           mem_read_ready,
    output logic [NUM_CHANNELS*DATA_BITS-1:0] mem_read_data,
    input  logic [NUM_CHANNELS-1:0]           mem_write_valid,
    input  logic [NUM_CHANNELS*ADDR_BITS-1:0] mem_write_address,
    input  logic [NUM_CHANNELS*DATA_BITS-1:0] mem_write_data,
    output logic [NUM_CHANNELS-1:0]           mem_write_ready,
    input  logic                              init_valid,
    input  logic [ADDR_BITS-1:0]              init_address,
    input  logic [DATA_BITS-1:0]              init_data
);

    localparam int unsigned DEPTH = 2 ** ADDR_BITS;
    localparam int unsigned CH_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

    logic [DATA_BITS-1:0] mem [DEPTH];

    logic                 rd_fire [NUM_CHANNELS];
    logic                 wr_fire [NUM_CHANNELS];
    logic [ADDR_BITS-1:0] rd_addr [NUM_CHANNELS];
    logic [ADDR_BITS-1:0] wr_addr [NUM_CHANNELS];
    logic [DATA_BITS-1:0] wr_data [NUM_CHANNELS];

    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_chan
        logic [DATA_BITS-1:0] rdata_q;

        mem_responder_channel #(
            .ADDR_BITS (ADDR_BITS),
            .DATA_BITS (DATA_BITS),
            .LATENCY   (LATENCY)
        ) u_chan (
            .clk           (clk),
            .reset         (reset),
            .read_valid    (mem_read_valid[c]),
            .read_address  (mem_read_address[c*ADDR_BITS +: ADDR_BITS]),
            .write_valid   (mem_write_valid[c]),
            .write_address (mem_write_address[c*ADDR_BITS +: ADDR_BITS]),
            .write_data    (mem_write_data[c*DATA_BITS +: DATA_BITS]),
            .read_ready    (mem_read_ready[c]),
            .write_ready   (mem_write_ready[c]),
            .rd_fire       (rd_fire[c]),
            .rd_addr       (rd_addr[c]),
            .wr_fire       (wr_fire[c]),
            .wr_addr       (wr_addr[c]),
            .wr_data       (wr_data[c])
        );

        // Sampled with the array's pre-edge contents, so a same-edge write is not visible.
        always_ff @(posedge clk) begin
            if (reset) begin
                rdata_q <= '0;
            end else if (rd_fire[c]) begin
                rdata_q <= mem[rd_addr[c]];
            end
        end

        assign mem_read_data[c*DATA_BITS +: DATA_BITS] = rdata_q;
    end

    // Later non-blocking writes override earlier ones: ascending channel order, init last.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[ADDR_BITS'(i)] <= '0;
            end
        end else begin
            for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
                if (WRITE_ENABLE != 0 && wr_fire[CH_W'(c)]) begin
                    mem[wr_addr[CH_W'(c)]] <= wr_data[CH_W'(c)];
                end
            end
            if (init_valid) begin
                mem[init_address] <= init_data;
            end
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench: a 2-channel LATENCY=2 writable instance and a
// 1-channel LATENCY=1 read-only instance sharing clock and reset.
module tb_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;

    logic [1:0]  rv, wv, rr, wr;
    logic [15:0] ra, wa;
    logic [31:0] wd, rdata;
    logic        iv;
    logic [7:0]  ia;
    logic [15:0] id;

    logic        ro_rv, ro_wv, ro_iv, ro_rr, ro_wr;
    logic [7:0]  ro_ra, ro_wa, ro_ia;
    logic [15:0] ro_wd, ro_id, ro_rdata;

    int n_cmp = 0;
    int n_err = 0;

    mem_responder #(
        .ADDR_BITS    (8),
        .DATA_BITS    (16),
        .NUM_CHANNELS (2),
        .LATENCY      (2),
        .WRITE_ENABLE (1)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .mem_read_valid    (rv),
        .mem_read_address  (ra),
        .mem_read_ready    (rr),
        .mem_read_data     (rdata),
        .mem_write_valid   (wv),
        .mem_write_address (wa),
        .mem_write_data    (wd),
        .mem_write_ready   (wr),
        .init_valid        (iv),
        .init_address      (ia),
        .init_data         (id)
    );

    mem_responder #(
        .ADDR_BITS    (8),
        .DATA_BITS    (16),
        .NUM_CHANNELS (1),
        .LATENCY      (1),
        .WRITE_ENABLE (0)
    ) dut_ro (
        .clk               (clk),
        .reset             (reset),
        .mem_read_valid    (ro_rv),
        .mem_read_address  (ro_ra),
        .mem_read_ready    (ro_rr),
        .mem_read_data     (ro_rdata),
        .mem_write_valid   (ro_wv),
        .mem_write_address (ro_wa),
        .mem_write_data    (ro_wd),
        .mem_write_ready   (ro_wr),
        .init_valid        (ro_iv),
        .init_address      (ro_ia),
        .init_data         (ro_id)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Read on channel ch with LATENCY=2: ready exactly two edges after accept, data held after.
    task automatic read_chk(input int ch, input logic [7:0] a, input logic [15:0] exp,
                            input string tag);
        rv[ch] = 1'b1;
        ra[ch*8 +: 8] = a;
        tick;
        rv[ch] = 1'b0;
        chk({tag, "_lat1"}, 32'(rr), 32'd0);
        tick;
        chk({tag, "_lat2"}, 32'(rr), 32'd0);
        tick;
        chk({tag, "_rdy"}, 32'(rr), 32'(1 << ch));
        chk({tag, "_data"}, 32'(rdata[ch*16 +: 16]), 32'(exp));
        tick;
        chk({tag, "_drop"}, 32'(rr), 32'd0);
        chk({tag, "_hold"}, 32'(rdata[ch*16 +: 16]), 32'(exp));
    endtask

    initial begin
        reset = 1'b1;
        rv = '0; wv = '0; ra = '0; wa = '0; wd = '0;
        iv = 1'b0; ia = '0; id = '0;
        ro_rv = 1'b0; ro_wv = 1'b0; ro_iv = 1'b0;
        ro_ra = '0; ro_wa = '0; ro_ia = '0; ro_wd = '0; ro_id = '0;

        tick;
        tick;
        chk("rst_rr", 32'(rr), 32'd0);
        chk("rst_wr", 32'(wr), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_ro_rdy", 32'({ro_rr, ro_wr}), 32'd0);
        chk("rst_ro_rdata", 32'(ro_rdata), 32'd0);
        reset = 1'b0;
        tick;

        // Backdoor load then read with a valid dropped right after accept
        iv = 1'b1; ia = 8'h10; id = 16'hBEEF;
        tick;
        iv = 1'b0;
        read_chk(0, 8'h10, 16'hBEEF, "init_rd");

        // Write then read back
        wv[0] = 1'b1; wa[7:0] = 8'h20; wd[15:0] = 16'h1234;
        tick;
        wv[0] = 1'b0;
        chk("wr_lat1", 32'(wr), 32'd0);
        tick;
        chk("wr_lat2", 32'(wr), 32'd0);
        tick;
        chk("wr_rdy", 32'(wr), 32'd1);
        tick;
        chk("wr_drop", 32'(wr), 32'd0);
        read_chk(0, 8'h20, 16'h1234, "wr_rd");

        // Same-edge writes to one address: channel 1 wins
        wv = 2'b11; wa = {8'h30, 8'h30}; wd = {16'h2222, 16'h1111};
        tick;
        wv = 2'b00;
        tick;
        tick;
        chk("dual_wr_rdy", 32'(wr), 32'd3);
        tick;
        read_chk(0, 8'h30, 16'h2222, "dual_rd");

        // Same-edge read (ch1) and write (ch0) to one address: read sees old value
        wv[0] = 1'b1; wa[7:0] = 8'h60; wd[15:0] = 16'h7777;
        rv[1] = 1'b1; ra[15:8] = 8'h60;
        tick;
        wv[0] = 1'b0; rv[1] = 1'b0;
        tick;
        tick;
        chk("rw_rr", 32'(rr), 32'd2);
        chk("rw_wr", 32'(wr), 32'd1);
        chk("rw_old", 32'(rdata[31:16]), 32'd0);
        tick;
        read_chk(1, 8'h60, 16'h7777, "rw_new");

        // Init on the same edge as a channel commit: init wins
        wv[0] = 1'b1; wa[7:0] = 8'h70; wd[15:0] = 16'h1111;
        tick;
        wv[0] = 1'b0;
        tick;
        iv = 1'b1; ia = 8'h70; id = 16'h9999;
        tick;
        iv = 1'b0;
        chk("init_win_rdy", 32'(wr), 32'd1);
        tick;
        read_chk(0, 8'h70, 16'h9999, "init_win");

        // Valid held past ready: single pulse, no re-accept while draining
        rv[0] = 1'b1; ra[7:0] = 8'h10;
        tick;
        tick;
        tick;
        chk("drain_rdy", 32'(rr), 32'd1);
        chk("drain_data", 32'(rdata[15:0]), 32'hBEEF);
        tick;
        chk("drain_c1", 32'(rr), 32'd0);
        tick;
        chk("drain_c2", 32'(rr), 32'd0);
        tick;
        chk("drain_c3", 32'(rr), 32'd0);
        rv[0] = 1'b0;
        tick;
        read_chk(0, 8'h20, 16'h1234, "post_drain");

        // Read-only instance, LATENCY=1: ready on the accept edge, array untouched
        ro_wv = 1'b1; ro_wa = 8'h50; ro_wd = 16'hAAAA;
        tick;
        ro_wv = 1'b0;
        chk("ro_wr_rdy", 32'(ro_wr), 32'd1);
        tick;
        chk("ro_wr_drop", 32'(ro_wr), 32'd0);
        ro_rv = 1'b1; ro_ra = 8'h50;
        tick;
        ro_rv = 1'b0;
        chk("ro_rd_rdy", 32'(ro_rr), 32'd1);
        chk("ro_rd_data", 32'(ro_rdata), 32'd0);
        tick;
        chk("ro_rd_drop", 32'(ro_rr), 32'd0);
        ro_iv = 1'b1; ro_ia = 8'h51; ro_id = 16'h3C3C;
        tick;
        ro_iv = 1'b0;
        ro_wv = 1'b1; ro_wa = 8'h51; ro_wd = 16'hAAAA;
        tick;
        ro_wv = 1'b0;
        chk("ro_wr2_rdy", 32'(ro_wr), 32'd1);
        tick;
        ro_rv = 1'b1; ro_ra = 8'h51;
        tick;
        ro_rv = 1'b0;
        chk("ro_rd2_data", 32'(ro_rdata), 32'h3C3C);
        tick;

        // Reset during BUSY_WR: no ready, no write, array and read data cleared
        wv[0] = 1'b1; wa[7:0] = 8'h40; wd[15:0] = 16'h5555;
        tick;
        wv[0] = 1'b0;
        reset = 1'b1;
        tick;
        chk("mid_rst_wr", 32'(wr), 32'd0);
        chk("mid_rst_rdata", rdata, 32'd0);
        reset = 1'b0;
        tick;
        chk("mid_rst_wr2", 32'(wr), 32'd0);
        tick;
        chk("mid_rst_wr3", 32'(wr), 32'd0);
        read_chk(0, 8'h40, 16'h0000, "mid_rst_rd");
        read_chk(1, 8'h10, 16'h0000, "rst_clear");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
